// File: rtl/display_scan_mux.sv
// Seven-segment scan multiplexer: walks NUM_DIGITS digit slots, drives the slot's
// nibble to the decoder and one active-low anode, with frame-aligned value updates.

module display_scan_digit #(
  parameter bit IS_LSD = 1'b0
) (
  input  logic [3:0] nib_i,
  input  logic       upper_zero_i,
  input  logic       en_i,
  input  logic       blank_lz_i,
  output logic       visible_o
);
  logic lz_blank;

  // The least significant digit always shows, so an all-zero value reads "0".
  assign lz_blank  = !IS_LSD && blank_lz_i && upper_zero_i && (nib_i == 4'd0);
  assign visible_o = en_i && !lz_blank;
endmodule

module display_scan_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 16,
  localparam int SEL_W = $clog2(NUM_DIGITS),
  localparam int CNT_W = $clog2(REFRESH_DIV)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
  output logic [3:0]              num_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [SEL_W-1:0]        digit_sel,
  output logic                    frame_done
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [NUM_DIGITS-1:0][3:0] act_q, act_d, pend_q, pend_d;
  logic pend_vld_q, pend_vld_d;
  logic slot_end, frame_end, in_guard;

  logic [NUM_DIGITS-1:0] upper_zero, visible;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [3:0]            num_q, num_d;
  logic                  fd_q, fd_d;

  assign slot_end  = (cnt_q == CNT_LAST);
  assign frame_end = slot_end && (sel_q == SEL_LAST);

  // Next-state view of the scan position; outputs are registered from it so
  // they line up exactly with the slot they describe.
  always_comb begin
    cnt_d      = slot_end ? '0 : cnt_q + 1'b1;
    sel_d      = frame_end ? '0 : (slot_end ? sel_q + 1'b1 : sel_q);
    act_d      = act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (frame_end) begin
      if (load)            act_d = value_in;
      else if (pend_vld_q) act_d = pend_q;
      pend_vld_d = 1'b0;
    end else if (load) begin
      pend_d     = value_in;
      pend_vld_d = 1'b1;
    end
  end

  if (GUARD_CYCLES > 0) begin : g_guard
    localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD_CYCLES);
    assign in_guard = (cnt_d < GUARD_C);
  end else begin : g_noguard
    assign in_guard = 1'b0;
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    if (g == NUM_DIGITS - 1) begin : g_top
      assign upper_zero[g] = 1'b1;
    end else begin : g_low
      assign upper_zero[g] = ~|act_d[NUM_DIGITS-1:g+1];
    end

    display_scan_digit #(.IS_LSD(g == 0)) u_dig (
      .nib_i        (act_d[g]),
      .upper_zero_i (upper_zero[g]),
      .en_i         (digit_en[g]),
      .blank_lz_i   (blank_lz),
      .visible_o    (visible[g])
    );
  end

  always_comb begin
    an_d = '1;
    if (!in_guard && visible[sel_d]) an_d[sel_d] = 1'b0;
  end

  assign num_d = act_d[sel_d];
  assign fd_d  = (sel_d == SEL_LAST) && (cnt_d == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      sel_q      <= '0;
      act_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      an_q       <= '1;
      num_q      <= '0;
      fd_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      act_q      <= act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      an_q       <= an_d;
      num_q      <= num_d;
      fd_q       <= fd_d;
    end
  end

  assign an         = an_q;
  assign num_out    = num_q;
  assign digit_sel  = sel_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux with 4 digits, 8-cycle slots, 2-cycle guard.

module tb_display_scan_mux;
  localparam logic [3:0][3:0] LIT_STD = 16'h7BDE;

  logic        clk;
  logic        rst_n;
  logic [15:0] value_in;
  logic        load;
  logic [3:0]  digit_en;
  logic        blank_lz;
  logic [3:0]  num_out;
  logic [3:0]  an;
  logic [1:0]  digit_sel;
  logic        frame_done;

  int passed = 0;
  int total  = 0;
  logic [10:0] obs [32];

  display_scan_mux #(.NUM_DIGITS(4), .REFRESH_DIV(8), .GUARD_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value_in   (value_in),
    .load       (load),
    .digit_en   (digit_en),
    .blank_lz   (blank_lz),
    .num_out    (num_out),
    .an         (an),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, want finish before 100000");
    $fatal(1, "watchdog");
  end

  // Expected {an, num_out, digit_sel, frame_done} at frame offset o, given the lit
  // anode pattern and displayed nibble for each slot.
  function automatic logic [10:0] exp_vec(input logic [3:0][3:0] lit,
                                          input logic [3:0][3:0] nib, input int o);
    int s;
    int p;
    s = o / 8;
    p = o % 8;
    exp_vec = {((p < 2) ? 4'hF : lit[s]), nib[s], 2'(s), (o == 31)};
  endfunction

  // Steps one 32-cycle frame from mid-cycle of offset 0, recording outputs and
  // applying up to two loads and one digit_en/blank_lz change at given offsets.
  task automatic capture_frame(input int la_off, input logic [15:0] la_val,
                               input int lb_off, input logic [15:0] lb_val,
                               input int c_off, input logic [3:0] c_en, input logic c_bl);
    for (int o = 0; o < 32; o++) begin
      #1;
      obs[o] = {an, num_out, digit_sel, frame_done};
      load = 1'b0;
      if (o == la_off) begin load = 1'b1; value_in = la_val; end
      if (o == lb_off) begin load = 1'b1; value_in = lb_val; end
      if (o == c_off) begin digit_en = c_en; blank_lz = c_bl; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; load = 1'b1; value_in = 16'hFFFF; digit_en = 4'hF; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({an, num_out, digit_sel, frame_done} !== 11'b1111_0000_00_0)
      $display("FAIL reset_state: got {an,num,sel,fd}=%b want 11110000000",
               {an, num_out, digit_sel, frame_done});
    else passed++;
    load = 1'b0; value_in = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_scan_and_load;
    logic [10:0] e;
    capture_frame(5, 16'h12A7, -1, 16'h0, -1, 4'hF, 1'b0);
    for (int o = 0; o < 32; o++) begin
      e = exp_vec(LIT_STD, 16'h0000, o);
      total++;
      if (obs[o] !== e) $display("FAIL scan_f0 off %0d: got %b want %b", o, obs[o], e);
      else passed++;
    end
    capture_frame(3, 16'h1111, 31, 16'h2222, -1, 4'hF, 1'b0);
    for (int o = 0; o < 32; o++) begin
      e = exp_vec(LIT_STD, 16'h12A7, o);
      total++;
      if (obs[o] !== e) $display("FAIL commit_f1 off %0d: got %b want %b", o, obs[o], e);
      else passed++;
    end
  endtask

  task automatic test_back_to_back;
    logic [10:0] e;
    capture_frame(10, 16'h0050, -1, 16'h0, 10, 4'hF, 1'b1);
    for (int o = 0; o < 32; o++) begin
      e = exp_vec(LIT_STD, 16'h2222, o);
      total++;
      if (obs[o] !== e) $display("FAIL last_wins_f2 off %0d: got %b want %b", o, obs[o], e);
      else passed++;
    end
  endtask

  task automatic test_blank_lz;
    logic [10:0] e;
    capture_frame(4, 16'h0000, -1, 16'h0, -1, 4'hF, 1'b1);
    for (int o = 0; o < 32; o++) begin
      e = exp_vec(16'hFFDE, 16'h0050, o);
      total++;
      if (obs[o] !== e) $display("FAIL blank_0050 off %0d: got %b want %b", o, obs[o], e);
      else passed++;
    end
    capture_frame(-1, 16'h0, -1, 16'h0, 31, 4'b1011, 1'b0);
    for (int o = 0; o < 32; o++) begin
      e = exp_vec(16'hFFFE, 16'h0000, o);
      total++;
      if (obs[o] !== e) $display("FAIL blank_0000 off %0d: got %b want %b", o, obs[o], e);
      else passed++;
    end
  endtask

  task automatic test_mask;
    logic [10:0] e;
    capture_frame(-1, 16'h0, -1, 16'h0, 4, 4'b1010, 1'b0);
    for (int o = 0; o < 32; o++) begin
      e = exp_vec(16'h7FDE, 16'h0000, o);
      if (o >= 5 && o < 8) e[10:7] = 4'hF;
      total++;
      if (obs[o] !== e) $display("FAIL mask off %0d: got %b want %b", o, obs[o], e);
      else passed++;
    end
  endtask

  task automatic test_async_reset;
    logic [10:0] e;
    for (int o = 0; o < 20; o++) begin
      #1;
      if (o == 0) digit_en = 4'hF;
      load = (o == 3);
      value_in = 16'hABCD;
      @(negedge clk);
    end
    #1;
    load = 1'b0;
    total++;
    if (an !== 4'b1011) $display("FAIL pre_reset_an: got %b want 1011", an);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({an, num_out, digit_sel, frame_done} !== 11'b1111_0000_00_0)
      $display("FAIL async_reset: got {an,num,sel,fd}=%b want 11110000000",
               {an, num_out, digit_sel, frame_done});
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int f = 0; f < 2; f++) begin
      capture_frame(-1, 16'h0, -1, 16'h0, -1, 4'hF, 1'b0);
      for (int o = 0; o < 32; o++) begin
        e = exp_vec(LIT_STD, 16'h0000, o);
        total++;
        if (obs[o] !== e)
          $display("FAIL post_reset_f%0d off %0d: got %b want %b", f, o, obs[o], e);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_and_load();
    test_back_to_back();
    test_blank_lz();
    test_mask();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
